// File: rtl/hamming_top.sv
// Hamming(16,11) SECDED encoder engine: reads 11-bit messages from an embedded
// byte memory, appends four Hamming parity bits plus overall parity, writes 16-bit codewords back.

module hamming_dmem #(
  parameter int ADDR_W = 8
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [7:0]        wdata_i,
  output logic [7:0]        rdata_o
);
  logic [7:0] Core [0:(1<<ADDR_W)-1];

  // Plain always so the array can also be preloaded and inspected hierarchically.
  always @(posedge clk_i) begin
    if (we_i) Core[addr_i] <= wdata_i;
  end

  assign rdata_o = Core[addr_i];
endmodule

module hamming_top #(
  parameter int NUM_MSGS = 15,
  parameter int IN_BASE  = 0,
  parameter int OUT_BASE = 30,
  parameter int ADDR_W   = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic Init,
  output logic done
);
  localparam int IDX_W = (NUM_MSGS > 1) ? $clog2(NUM_MSGS) : 1;
  localparam logic [ADDR_W-1:0] IN_A  = ADDR_W'(IN_BASE);
  localparam logic [ADDR_W-1:0] OUT_A = ADDR_W'(OUT_BASE);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_LO = 3'd1,
    RD_HI = 3'd2,
    WR_LO = 3'd3,
    WR_HI = 3'd4,
    FIN   = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [7:0]        lo_q, lo_d;
  logic [2:0]        hi_q, hi_d;
  logic              done_q, done_d;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [ADDR_W-1:0] msg_off;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;
  logic [15:0]       code;
  logic              last_msg;
  logic              unused_hi_bits;

  // Codeword layout {d11..d5,p8, d4..d2,p4, d1,p2,p1,p0}; p0 makes the word even parity.
  function automatic logic [15:0] hamming_encode(input logic [11:1] d);
    logic p8, p4, p2, p1, p0;
    p8 = ^d[11:5];
    p4 = (^d[11:8]) ^ (^d[4:2]);
    p2 = d[11] ^ d[10] ^ d[7] ^ d[6] ^ d[4] ^ d[3] ^ d[1];
    p1 = d[11] ^ d[9] ^ d[7] ^ d[5] ^ d[4] ^ d[2] ^ d[1];
    p0 = (^d) ^ p8 ^ p4 ^ p2 ^ p1;
    return {d[11:5], p8, d[4:2], p4, d[1], p2, p1, p0};
  endfunction

  hamming_dmem #(.ADDR_W(ADDR_W)) data_mem (
    .clk_i   (clk),
    .we_i    (mem_we),
    .addr_i  (mem_addr),
    .wdata_i (mem_wdata),
    .rdata_o (mem_rdata)
  );

  assign msg_off        = ADDR_W'({idx_q, 1'b0});
  assign last_msg       = (idx_q == IDX_W'(NUM_MSGS - 1));
  assign code           = hamming_encode({hi_q, lo_q});
  assign unused_hi_bits = ^mem_rdata[7:3];
  assign done           = done_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_q  <= '0;
      lo_q   <= '0;
      hi_q   <= '0;
      done_q <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      lo_q   <= lo_d;
      hi_q   <= hi_d;
      done_q <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (Init) state_d = RD_LO;
      RD_LO:   state_d = RD_HI;
      RD_HI:   state_d = WR_LO;
      WR_LO:   state_d = WR_HI;
      WR_HI:   state_d = last_msg ? FIN : RD_LO;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = IN_A + msg_off;
    mem_wdata = 8'h00;
    idx_d     = idx_q;
    lo_d      = lo_q;
    hi_d      = hi_q;
    done_d    = done_q;
    case (state_q)
      IDLE:  if (Init) done_d = 1'b0;
      RD_LO: lo_d = mem_rdata;
      RD_HI: begin
        mem_addr = IN_A + msg_off + 8'd1;
        hi_d     = mem_rdata[2:0];
      end
      WR_LO: begin
        mem_we    = 1'b1;
        mem_addr  = OUT_A + msg_off;
        mem_wdata = code[7:0];
      end
      WR_HI: begin
        mem_we    = 1'b1;
        mem_addr  = OUT_A + msg_off + 8'd1;
        mem_wdata = code[15:8];
        if (!last_msg) idx_d = idx_q + 1'b1;
      end
      FIN: begin
        done_d = 1'b1;
        idx_d  = '0;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_hamming_top.sv
// Scoreboard bench for hamming_top: stimulus pushes expected codeword images,
// a monitor pops and checks memory whenever done rises.

module tb_hamming_top;
  logic clk;
  logic reset;
  logic Init;
  logic done;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    int           init_cyc;
    logic [239:0] words;
    logic [239:0] inputs;
  } exp_t;

  exp_t sb[$];

  hamming_top dut (
    .clk   (clk),
    .reset (reset),
    .Init  (Init),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Reference encoder built from codeword bit positions: parity bit k covers every position with bit k set.
  function automatic logic [15:0] ref_code(input logic [10:0] d);
    logic [15:0] w;
    int j;
    logic par;
    w = '0;
    j = 0;
    for (int pos = 1; pos < 16; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        w[pos] = d[j];
        j++;
      end
    end
    for (int k = 1; k < 16; k = k * 2) begin
      par = 1'b0;
      for (int pos = 1; pos < 16; pos++)
        if ((pos & k) != 0) par = par ^ w[pos];
      w[k] = par;
    end
    w[0] = ^w[15:1];
    return w;
  endfunction

  function automatic logic [239:0] expected_words(input logic [239:0] img);
    logic [239:0] w;
    logic [10:0]  d;
    for (int i = 0; i < 15; i++) begin
      d = {img[8*(2*i+1) +: 3], img[16*i +: 8]};
      w[16*i +: 16] = ref_code(d);
    end
    return w;
  endfunction

  task automatic start_run(input logic [239:0] img, input logic [239:0] w,
                           input int n_push, input bit hold);
    exp_t e;
    repeat (2) @(negedge clk);
    for (int a = 0; a < 30; a++) dut.data_mem.Core[a] = img[8*a +: 8];
    for (int a = 30; a < 60; a++) dut.data_mem.Core[a] = 8'hEE;
    for (int k = 0; k < n_push; k++) begin
      e.init_cyc = cyc + 1 + 62 * k;
      e.words    = w;
      e.inputs   = img;
      sb.push_back(e);
    end
    Init = 1'b1;
    @(negedge clk);
    if (!hold) Init = 1'b0;
    check("done_clear_on_start", done, 1'b0);
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin : monitor
    logic        done_prev;
    exp_t        e;
    int          bad;
    logic [15:0] got;
    done_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (done === 1'b1 && done_prev !== 1'b1) begin
        check("done_expected", (sb.size() != 0), 1'b1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("done_latency", cyc - e.init_cyc, 61);
          for (int i = 0; i < 15; i++) begin
            got = {dut.data_mem.Core[31+2*i], dut.data_mem.Core[30+2*i]};
            check($sformatf("word%0d", i), got, e.words[16*i +: 16]);
          end
          bad = 0;
          for (int a = 0; a < 30; a++)
            if (dut.data_mem.Core[a] !== e.inputs[8*a +: 8]) bad++;
          check("inputs_unchanged", bad, 0);
          bad = 0;
          for (int a = 60; a < 256; a++)
            if (dut.data_mem.Core[a] !== (8'(a) ^ 8'h5A)) bad++;
          check("upper_untouched", bad, 0);
        end
      end
      done_prev = done;
    end
  end

  initial begin : stimulus
    logic [239:0] img;
    logic [239:0] w;
    bit           ok;

    reset = 1'b1;
    Init  = 1'b0;
    for (int a = 60; a < 256; a++) dut.data_mem.Core[a] = 8'(a) ^ 8'h5A;
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_done", done, 1'b0);
    check("reset_state", dut.state_q, 3'd0);
    reset = 1'b1;
    @(negedge clk);

    // Run 1: directed corner messages first, then filler messages with junk high bits.
    img = '0;
    img[7:0]   = 8'h00; img[15:8]  = 8'h00;
    img[23:16] = 8'h01; img[31:24] = 8'h00;
    img[39:32] = 8'h00; img[47:40] = 8'h04;
    img[55:48] = 8'hFF; img[63:56] = 8'hFF;
    for (int i = 4; i < 15; i++) begin
      img[16*i +: 8]     = 8'(i * 37 + 11);
      img[16*i + 8 +: 8] = 8'(i * 53);
    end
    w = expected_words(img);
    w[15:0]  = 16'h0000;
    w[31:16] = 16'h000F;
    w[47:32] = 16'h8117;
    w[63:48] = 16'hFFFF;
    start_run(img, w, 1, 1'b0);
    wait_done(100, ok);
    check("run1_done_seen", ok, 1'b1);

    repeat (3) @(negedge clk);
    check("done_held_high", done, 1'b1);

    // Run 2: random messages, plus an Init pulse mid-run that must be ignored.
    for (int a = 0; a < 30; a++) img[8*a +: 8] = 8'($urandom);
    w = expected_words(img);
    start_run(img, w, 1, 1'b0);
    repeat (28) @(negedge clk);
    Init = 1'b1;
    @(negedge clk);
    Init = 1'b0;
    wait_done(100, ok);
    check("run2_done_seen", ok, 1'b1);

    // Run 3: reset lands around cycle 20 of a run, then a clean restart.
    start_run(img, w, 0, 1'b0);
    repeat (18) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("abort_done_low", done, 1'b0);
    check("abort_state_idle", dut.state_q, 3'd0);
    check("abort_idx_zero", dut.idx_q, 4'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    start_run(img, w, 1, 1'b0);
    wait_done(100, ok);
    check("run3_done_seen", ok, 1'b1);

    // Run 4: Init held high restarts immediately after each completion.
    for (int a = 0; a < 30; a++) img[8*a +: 8] = 8'($urandom);
    w = expected_words(img);
    start_run(img, w, 2, 1'b1);
    wait_done(100, ok);
    check("run4a_done_seen", ok, 1'b1);
    for (int i = 0; i < 5 && done === 1'b1; i++) @(negedge clk);
    check("run4_done_pulse_cleared", done, 1'b0);
    wait_done(100, ok);
    Init = 1'b0;
    check("run4b_done_seen", ok, 1'b1);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
